// File: rtl/loader_pkg.sv
// Shared definitions for the boot loader: dual-rail write-port encodings and
// the loader FSM state type.
package loader_pkg;

  // Dual-rail read_Nwrite encodings (rail1, rail0).
  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;  // write
  localparam logic [1:0] DR_ONE  = 2'b10;  // read (never issued by the loader)

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/sync_ff.sv
// Flop-chain synchronizer for a single asynchronous level.
//   clk, rst : clock and synchronous active-high reset (chain clears to 0)
//   d        : asynchronous input
//   q        : synchronized output, STAGES cycles of latency
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams host words into consecutive memory addresses over a
// dual-rail four-phase RTZ write port, holding the CPU in reset until done.
//   start/base_addr/word_count : load request (sampled when not busy)
//   in_valid/in_data/in_ready  : host word stream
//   mem_addr/mem_data/mem_rw   : bundled-data write port, mem_ack_write back
//   cpu_rst_n                  : active-low CPU reset, released on completion
//   busy/done/err              : status (done/err sticky until start or rst)
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [1:0]        mem_rw,
  input  logic              mem_ack_write,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remain_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              ack_s;
  logic              start_ok;
  logic              tmo_hit;
  logic              word_acked;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (mem_ack_write),
    .q   (ack_s)
  );

  // Next-state logic; start is only honoured outside an active load.
  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    word_acked = 1'b0;
    tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (word_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: if (in_valid) state_d = S_SETUP;
      S_SETUP: state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (ack_s)        state_d = S_WAIT_LO;
        else if (tmo_hit) state_d = S_ERROR;
      end
      S_WAIT_LO: begin
        if (!ack_s) begin
          word_acked = 1'b1;
          state_d    = (remain_q == CNT_W'(1)) ? S_DONE : S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered outputs (decoded from next state) and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_rw    <= DR_NULL;
      cpu_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      addr_q    <= '0;
      remain_q  <= '0;
      tmo_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == S_FETCH);
      mem_rw    <= (state_d == S_WAIT_HI) ? DR_ZERO : DR_NULL;
      cpu_rst_n <= (state_d == S_DONE);
      done      <= (state_d == S_DONE);
      err       <= (state_d == S_ERROR);
      busy      <= (state_d == S_FETCH) || (state_d == S_SETUP) ||
                   (state_d == S_WAIT_HI) || (state_d == S_WAIT_LO);

      if (start_ok) begin
        addr_q   <= base_addr;
        remain_q <= word_count;
      end

      // Bundled data is only allowed to change while fetching.
      if (state_q == S_FETCH && in_valid) begin
        mem_addr <= addr_q;
        mem_data <= in_data;
      end

      if (word_acked) begin
        addr_q   <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - CNT_W'(1);
      end

      // Timeout restarts on every state entry and runs only while waiting on ack.
      if (state_d != state_q)
        tmo_cnt <= '0;
      else if (state_q == S_WAIT_HI || state_q == S_WAIT_LO)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader with a behavioural memory model.
module tb_prog_loader;

  localparam logic [1:0] RW_NULL  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_rw;
  logic        mem_ack_write = 1'b0;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader #(.ADDR_W(8), .DATA_W(16), .SYNC_STAGES(2), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rw(mem_rw), .mem_ack_write(mem_ack_write), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_model [256];
  logic [15:0] ref_mem   [256];
  int          checks = 0;
  int          errors = 0;
  int          ack_dly = 0;
  int          ack_cnt = 0;
  bit          never_ack = 1'b0;
  logic [7:0]  held_addr;
  logic [15:0] held_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Four-phase memory: ack rises ack_dly cycles after a write request, falls
  // ack_dly cycles after the null spacer. Each write is popped and scored.
  always @(negedge clk) begin
    if (rst) begin
      mem_ack_write = 1'b0;
      ack_cnt = 0;
    end else begin
      if (mem_rw != RW_NULL && mem_rw != RW_WRITE) chk("mem_rw_legal", 32'(mem_rw), 32'(RW_NULL));
      if (cpu_rst_n && (mem_ack_write || busy)) chk("cpu_rst_early", 32'(cpu_rst_n), 0);
      if (mem_rw == RW_WRITE && !mem_ack_write) begin
        if (!never_ack) begin
          if (ack_cnt >= ack_dly) begin
            mem_ack_write = 1'b1;
            ack_cnt = 0;
            mem_model[mem_addr] = mem_data;
            held_addr = mem_addr;
            held_data = mem_data;
            if (exp_q.size() == 0) begin
              chk("spurious_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              chk("wr_addr", 32'(mem_addr), 32'(e.addr));
              chk("wr_data", 32'(mem_data), 32'(e.data));
            end
          end else ack_cnt++;
        end
      end else if (mem_rw == RW_NULL && mem_ack_write) begin
        if (ack_cnt >= ack_dly) begin
          chk("bundle_hold", {8'(mem_addr), 16'(mem_data)}, {8'(held_addr), 16'(held_data)});
          mem_ack_write = 1'b0;
          ack_cnt = 0;
        end else ack_cnt++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_mem_rw"}, 32'(mem_rw), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_data"}, 32'(mem_data), 0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic pulse_start(input logic [7:0] b, input int c);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    word_count = 9'(c);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one host word; the reference model records where it must land.
  task automatic send_word(input logic [7:0] a, input bit bp);
    logic [15:0] w;
    int n;
    w = 16'($urandom);
    if (bp) begin
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      chk("bp_reach_fetch", 32'(in_ready), 1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 1);
        chk("bp_mem_rw", 32'(mem_rw), 32'(RW_NULL));
      end
    end
    in_valid = 1'b1;
    in_data = w;
    exp_q.push_back('{addr: a, data: w});
    ref_mem[a] = w;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("word_accepted", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] b, input int c,
                          input bit bp, input bit poke_start);
    ack_dly = $urandom_range(0, 4);
    pulse_start(b, c);
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    chk({tag, "_cpu_held"}, 32'(cpu_rst_n), 0);
    chk({tag, "_err_cleared"}, 32'(err), 0);
    for (int i = 0; i < c; i++) begin
      send_word(8'((32'(b) + i) % 256), bp && i > 0);
      if (poke_start && i == 0) begin
        chk({tag, "_busy_before_poke"}, 32'(busy), 1);
        pulse_start(8'(b + 8'h40), 5);
      end
    end
    wait_done(tag);
    for (int i = 0; i < c; i++) begin
      logic [7:0] a;
      a = 8'((32'(b) + i) % 256);
      chk({tag, "_mem_content"}, 32'(mem_model[a]), 32'(ref_mem[a]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin mem_model[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Basic load and address wrap-around.
    run_load("basic", 8'h10, 3, 1'b0, 1'b0);
    run_load("wrap", 8'hFE, 3, 1'b0, 1'b0);

    // Zero count completes immediately with no memory traffic.
    pulse_start(8'h33, 0);
    chk("zero_done", 32'(done), 1);
    chk("zero_cpu_rst_n", 32'(cpu_rst_n), 1);
    chk("zero_mem_rw", 32'(mem_rw), 32'(RW_NULL));

    // Host backpressure between words.
    run_load("bp", 8'($urandom), 3, 1'b1, 1'b0);

    // start while busy must not disturb the running load.
    run_load("ignore_start", 8'($urandom), 2, 1'b0, 1'b1);

    // Randomized loads.
    for (int k = 0; k < 6; k++)
      run_load("rand", 8'($urandom), $urandom_range(1, 8), 1'($urandom), 1'b0);

    // Ack timeout: err rises TIMEOUT cycles after the write request.
    never_ack = 1'b1;
    pulse_start(8'h80, 2);
    send_word(8'h80, 1'b0);
    n = 0;
    while (mem_rw != RW_WRITE && n < 50) begin @(negedge clk); n++; end
    chk("tmo_req_seen", 32'(mem_rw), 32'(RW_WRITE));
    n = 0;
    while (!err && n < 100) begin @(negedge clk); n++; end
    chk("tmo_latency", 32'(n), 20);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_mem_rw", 32'(mem_rw), 32'(RW_NULL));
    chk("tmo_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("tmo_busy", 32'(busy), 0);
    exp_q.delete();
    never_ack = 1'b0;
    run_load("after_tmo", 8'h80, 2, 1'b0, 1'b0);

    // Reset in the middle of a write handshake.
    ack_dly = 3;
    pulse_start(8'h20, 3);
    send_word(8'h20, 1'b0);
    n = 0;
    while (mem_rw != RW_WRITE && n < 50) begin @(negedge clk); n++; end
    chk("midrst_req_seen", 32'(mem_rw), 32'(RW_WRITE));
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    exp_q.delete();
    run_load("after_rst", 8'h20, 3, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Clocked boot loader that sits directly upstream of the asynchronous CPU's instruction/data memory. It accepts 16-bit program words from a synchronous host over a valid/ready stream and writes them into consecutive memory addresses. The memory's write port uses the dual-rail, four-phase return-to-zero protocol. The loader holds the CPU in reset (`cpu_rst_n` low) until the programmed word count has been written, then releases it.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 16: program word width.
- `SYNC_STAGES`, 2: flops in the `mem_ack_write` synchronizer (≥2).
- `TIMEOUT`, 255: cycles allowed per ack edge before error.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a load.
- `base_addr`, in, `ADDR_W`: first write address, sampled on `start`.
- `word_count`, in, `ADDR_W`+1: words to load (0..256), sampled on `start`.
- `in_valid`, in, 1: host word valid.
- `in_data`, in, `DATA_W`: host word.
- `in_ready`, out, 1: loader accepts the word this cycle.
- `mem_addr`, out, `ADDR_W`: bundled address to memory.
- `mem_data`, out, `DATA_W`: bundled write data to memory.
- `mem_rw`, out, 2: dual-rail read_Nwrite (00 null, 01 write, 10 read, 11 illegal).
- `mem_ack_write`, in, 1: asynchronous write acknowledge from memory.
- `cpu_rst_n`, out, 1: active-low reset to the asynchronous CPU.
- `busy`, out, 1: load in progress.
- `done`, out, 1: load completed; sticky until next `start` or `rst`.
- `err`, out, 1: ack timeout; sticky until next `start` or `rst`.

## Operation
- **States:** IDLE, FETCH, SETUP, WAIT_HI, WAIT_LO, DONE, ERROR.
- **IDLE:** `start` latches `base_addr` and `word_count` and clears `done`/`err`.
  - Count 0 → DONE.
  - Otherwise → FETCH.
- **FETCH:** `in_ready`=1. On `in_valid`, register `in_data` to `mem_data` and the current address to `mem_addr` → SETUP.
- **SETUP:** one cycle of bundled-data setup with `mem_rw`=00. Then drive `mem_rw`=01 → WAIT_HI.
- **WAIT_HI:** hold `mem_rw`=01 and `mem_addr`/`mem_data` stable until synchronized ack=1. Then drive `mem_rw`=00 → WAIT_LO.
- **WAIT_LO:** hold `mem_rw`=00 until synchronized ack=0. Then increment the address and decrement the remaining count.
  - Remaining count 0 → DONE.
  - Otherwise → FETCH.
- **DONE:** `done`=1, `cpu_rst_n`=1. `start` re-enters a new load, which drives `cpu_rst_n`=0 again.
- **ERROR:** entered when the timeout counter reaches `TIMEOUT` in WAIT_HI or WAIT_LO.
  - Outputs: `mem_rw`=00, `err`=1, `cpu_rst_n`=0.
  - Exit only via `start` or `rst`.
- **Address arithmetic:** modulo 2^`ADDR_W`. Base 0xFF with count 2 writes 0xFF then 0x00.
- `start` while `busy` is ignored.
- `mem_rw` never takes the values 10 or 11.
- `in_ready` is asserted only in FETCH.

## Timing
- **Reset values** (one edge after `rst`): state IDLE, `mem_rw`=00, `mem_addr`=0, `mem_data`=0, `in_ready`=0, `cpu_rst_n`=0, `busy`=0, `done`=0, `err`=0.
- **Reset mid-handshake:** `mem_rw` returns to 00 on the next edge. The memory sees a null spacer; no recovery sequence is required.
- `busy`=1 in FETCH, SETUP, WAIT_HI and WAIT_LO.
- **Ack synchronizer:** `SYNC_STAGES` cycles of latency. A zero-delay memory gives a minimum of 1 (FETCH) + 1 (SETUP) + `SYNC_STAGES` + 1 + `SYNC_STAGES` cycles per word = 7 cycles at default.
- **Timeout counter:** reset on every state entry; counts only in WAIT_HI and WAIT_LO.
- **`cpu_rst_n` release:** rises on the same edge that enters DONE, never before the final ack has returned low.
- **Bundled-data rule:** `mem_addr`/`mem_data` change only in FETCH. They are stable from SETUP until WAIT_LO exits.

## Structure
- Shared package `loader_pkg`:
  - dual-rail constants `DR_NULL`=2'b00, `DR_ZERO`=2'b01, `DR_ONE`=2'b10;
  - state enum `loader_state_t`.
- Sub-module `sync_ff`: parameterized flop-chain synchronizer for `mem_ack_write`, reset to 0.
- FSM, address/count registers and timeout counter live in `prog_loader`.

## Test plan
- **Basic load:** `rst`, `start` with base 0x10, count 3, host words 0xA001/0xA002/0xA003, memory model acks after 3 cycles → memory 0x10..0x12 holds those words; `done`=1; `cpu_rst_n` rises after the third ack falls.
- **Wrap-around:** base 0xFE, count 3 → writes land at 0xFE, 0xFF, 0x00.
- **Zero count:** `start` with count 0 → `done`=1 and `cpu_rst_n`=1 one cycle later; `mem_rw` stays 00 throughout.
- **Host backpressure:** `in_valid` low for 10 cycles between words → `mem_rw` stays 00, `in_ready` stays high, no spurious write.
- **Timeout:** memory never acks with `TIMEOUT`=20 → `err`=1 twenty cycles after WAIT_HI entry, `mem_rw`=00, `cpu_rst_n`=0; a subsequent `start` clears `err` and restarts the load.
- **Reset mid-write:** assert `rst` during WAIT_HI → all outputs at reset values on the next edge; `start` while `busy` is shown to be ignored.
